calcu_core: RTL and testbench
=============================

# calcu_core

Parametrised calculator engine for the mouse-driven VGA calculator. It hit-tests clicks against a 4×4 on-screen keypad plus a clear key, and accepts multi-digit operands of up to DIGITS decimal digits. Add, subtract and multiply complete in one cycle; divide and modulo run on an iterative divider. Value, sign, operator symbol and error status go to the drawing logic.

## Interface
- DIGITS, 3: max decimal digits per operand (1..4); W = $clog2(10**DIGITS) operand bits, RW = 2*W result bits
- KEY_SIZE, 64: key edge in pixels
- ORIGIN_X, 90: left edge of keypad column 0
- ORIGIN_Y, 150: top edge of keypad row 0
- GAP_Y, 25: vertical gap between rows
- CLR_X, 560: left edge of clear key
- CLR_Y, 150: top edge of clear key
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mousex  in  10  cursor x
- mousey  in  10  cursor y
- mouseclick  in  1  button level
- disp_value  out  RW  magnitude to draw
- disp_neg  out  1  result is negative
- disp_sym  out  7  operator code: 97 %, 98 /, 99 +, 100 -, 101 x, 103 none
- busy  out  1  divider running
- err  out  1  divide/modulo by zero

## Operation
- Key geometry:
  - column c spans x = ORIGIN_X+2c·KEY_SIZE .. ORIGIN_X+(2c+1)·KEY_SIZE, inclusive.
  - row r spans y = ORIGIN_Y+r·(KEY_SIZE+GAP_Y) .. that +KEY_SIZE, inclusive.
  - layout, rows top to bottom: 1 2 3 = / 4 5 6 % / 7 8 9 ÷ / 0 + − ×.
  - clear key spans CLR_X..CLR_X+KEY_SIZE, CLR_Y..CLR_Y+KEY_SIZE.
  - a click outside every key is ignored.
- Event: rising edge of mouseclick (mouseclick=1, click_d=0). Position is sampled in that cycle. A held button produces exactly one event.
- States: S_A, S_B, S_DIV, S_RES, S_ERR.
- S_A:
  - digit d with cntA<DIGITS: A←A·10+d, cntA++, disp_value←A.
  - digit with cntA=DIGITS: ignored.
  - operator with cntA≥1: store op, disp_sym←op, go to S_B. With cntA=0: ignored.
- S_B:
  - digit: same rule, applied to B; disp_value←B.
  - operator with cntB=0: replaces op. With cntB≥1: ignored.
  - '=' with cntB≥1:
    - +, − or ×: go to S_RES, result loaded.
    - ÷ or % with B=0: go to S_ERR, err←1.
    - ÷ or % with B≠0: go to S_DIV, busy←1.
- Arithmetic:
  - − is A−B. If A<B: disp_neg=1 and disp_value=B−A.
  - × is the full RW-bit product.
  - ÷ gives the quotient; % gives the remainder.
- S_DIV: only clear is honoured.
- S_RES:
  - digit: new calculation. A←d, cntA=1, B=0, op=none, disp_neg=0, go to S_A.
  - operator (chaining) when disp_neg=0 and result<10**DIGITS: A←result, cntA=DIGITS, B=0, op stored, go to S_B. Otherwise ignored.
- S_ERR: only clear is honoured.
- Clear, from any state (aborts a running division): all registers take their reset values.
- Reset values: S_A; A=B=0; cntA=cntB=0; disp_value=0; disp_neg=0; disp_sym=103; busy=0; err=0; click_d=1.
- click_d=1 at reset means a button still held through reset generates no event.

## Timing
- Event in cycle t: registers update at the end of cycle t, so the outputs show the change in cycle t+1.
- +, −, ×: disp_value is valid one cycle after the '=' event.
- ÷ and %:
  - edge E0 (the '=' event): divider loaded, busy=1.
  - edges E1..EW: one restoring iteration each.
  - at EW: busy=0, S_RES, disp_value updated. busy is high for exactly W cycles.
- rst has priority over any event. The outputs after a reset edge are the reset values, including mid-division.
- A clear event during S_DIV: busy=0 on the next cycle; the divider result is discarded.

## Structure
- Package calcu_pkg:
  - operator codes 97..101 and SYM_NONE=103.
  - key enum: digits 0-9, EQ, MOD, DIV, ADD, SUB, MUL, CLR, NONE.
  - state enum.
- Sub-module calcu_divider:
  - restoring, W iterations, start/done handshake.
  - outputs quotient and remainder; synchronous clear input.
- Hit-test is a combinational function in calcu_core.

## Test plan
- 1,2,+,3,4,= → disp_value=46, disp_sym=99, disp_neg=0, one cycle after '='.
- 7,−,9,= → disp_value=2, disp_neg=1. 3,+,×,4,= → 12 (operator replaced).
- DIGITS=3: 1,2,3,4 → A=123, fourth digit ignored.
- DIGITS=3: 9,9,9,÷,7,= → busy high 10 cycles, then 142. Repeat with % → 5.
- 5,÷,0,= → err=1. Following digits are ignored. Clear → all reset values.
- Button held 100 cycles on key 8 → A=8 once. Click at x=154,y=150 → digit 1 registers. Click at x=155,y=150 → ignored.
- Clear, and separately rst, during S_DIV → reset values next cycle, busy=0.
- Button held through rst → no event after reset.

Source files
------------

// File: rtl/calcu_pkg.sv
// Shared types and constants for the VGA calculator engine:
// operator symbol codes, keypad key codes, FSM states.
package calcu_pkg;

    localparam logic [6:0] SYM_MOD  = 7'd97;
    localparam logic [6:0] SYM_DIV  = 7'd98;
    localparam logic [6:0] SYM_ADD  = 7'd99;
    localparam logic [6:0] SYM_SUB  = 7'd100;
    localparam logic [6:0] SYM_MUL  = 7'd101;
    localparam logic [6:0] SYM_NONE = 7'd103;

    typedef enum logic [4:0] {
        K_0, K_1, K_2, K_3, K_4,
        K_5, K_6, K_7, K_8, K_9,
        K_EQ, K_MOD, K_DIV, K_ADD,
        K_SUB, K_MUL, K_CLR, K_NONE
    } key_e;

    typedef enum logic [2:0] {
        S_A, S_B, S_DIV, S_RES, S_ERR
    } state_e;

    function automatic key_e key_at(
        input int r,
        input int c
    );
        key_e k;
        case (r * 4 + c)
            0:       k = K_1;
            1:       k = K_2;
            2:       k = K_3;
            3:       k = K_EQ;
            4:       k = K_4;
            5:       k = K_5;
            6:       k = K_6;
            7:       k = K_MOD;
            8:       k = K_7;
            9:       k = K_8;
            10:      k = K_9;
            11:      k = K_DIV;
            12:      k = K_0;
            13:      k = K_ADD;
            14:      k = K_SUB;
            15:      k = K_MUL;
            default: k = K_NONE;
        endcase
        return k;
    endfunction

    function automatic logic [6:0] key_sym(input key_e k);
        logic [6:0] s;
        case (k)
            K_MOD:   s = SYM_MOD;
            K_DIV:   s = SYM_DIV;
            K_ADD:   s = SYM_ADD;
            K_SUB:   s = SYM_SUB;
            K_MUL:   s = SYM_MUL;
            default: s = SYM_NONE;
        endcase
        return s;
    endfunction

    function automatic logic is_op(input key_e k);
        return k inside {K_MOD, K_DIV, K_ADD, K_SUB, K_MUL};
    endfunction

    function automatic logic is_digit(input key_e k);
        return k <= K_9;
    endfunction

endpackage

// File: rtl/calcu_divider.sv
// Restoring divider, one quotient bit per cycle, W cycles.
// o_done/o_quo/o_rem reflect the iteration of the current cycle.
module calcu_divider #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_done,
    output logic [W-1:0] o_quo,
    output logic [W-1:0] o_rem
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_dvs;
    logic [CW-1:0] r_cnt;

    logic [W:0]    w_sh;
    logic          w_ok;
    logic [W-1:0]  w_sub;
    logic [W-1:0]  w_rem_nx;

    assign w_sh     = {r_rem, r_quo[W-1]};
    assign w_ok     = (w_sh >= {1'b0, r_dvs});
    assign w_sub    = w_sh[W-1:0] - r_dvs;
    assign w_rem_nx = w_ok ? w_sub : w_sh[W-1:0];

    assign o_done = (r_cnt == CW'(1));
    assign o_quo  = {r_quo[W-2:0], w_ok};
    assign o_rem  = w_rem_nx;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
            r_cnt <= CW'(W);
        end else if (r_cnt != '0) begin
            r_quo <= o_quo;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/calcu_core.sv
// Calculator engine: keypad hit-test, operand entry FSM,
// single-cycle + - x and iterative / %.
module calcu_core
    import calcu_pkg::*;
#(
    parameter  int DIGITS   = 3,
    parameter  int KEY_SIZE = 64,
    parameter  int ORIGIN_X = 90,
    parameter  int ORIGIN_Y = 150,
    parameter  int GAP_Y    = 25,
    parameter  int CLR_X    = 560,
    parameter  int CLR_Y    = 150,
    localparam int W        = $clog2(10 ** DIGITS),
    localparam int RW       = 2 * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    mousex,
    input  logic [9:0]    mousey,
    input  logic          mouseclick,
    output logic [RW-1:0] disp_value,
    output logic          disp_neg,
    output logic [6:0]    disp_sym,
    output logic          busy,
    output logic          err
);

    localparam int CW    = $clog2(DIGITS + 1);
    localparam int LIMIT = 10 ** DIGITS;

    function automatic key_e hit_test(
        input logic [9:0] x,
        input logic [9:0] y
    );
        int   xi;
        int   yi;
        int   y0;
        key_e k;
        xi = int'(x);
        yi = int'(y);
        k  = K_NONE;
        for (int r = 0; r < 4; r++) begin
            y0 = ORIGIN_Y + r * (KEY_SIZE + GAP_Y);
            for (int c = 0; c < 4; c++) begin
                if (xi >= ORIGIN_X + 2 * c * KEY_SIZE &&
                    xi <= ORIGIN_X + (2 * c + 1) * KEY_SIZE &&
                    yi >= y0 && yi <= y0 + KEY_SIZE)
                    k = key_at(r, c);
            end
        end
        if (xi >= CLR_X && xi <= CLR_X + KEY_SIZE &&
            yi >= CLR_Y && yi <= CLR_Y + KEY_SIZE)
            k = K_CLR;
        return k;
    endfunction

    logic          r_click_d;
    state_e        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [CW-1:0] r_cnta;
    logic [CW-1:0] r_cntb;
    logic [RW-1:0] r_val;
    logic          r_neg;
    logic [6:0]    r_sym;
    logic          r_err;

    state_e        w_state_nx;
    logic [W-1:0]  w_a_nx;
    logic [W-1:0]  w_b_nx;
    logic [CW-1:0] w_cnta_nx;
    logic [CW-1:0] w_cntb_nx;
    logic [RW-1:0] w_val_nx;
    logic          w_neg_nx;
    logic [6:0]    w_sym_nx;
    logic          w_err_nx;
    logic          w_start;

    logic          w_evt;
    key_e          w_key;
    logic          w_clr;
    logic [W-1:0]  w_digit;
    logic [W-1:0]  w_a_dig;
    logic [W-1:0]  w_b_dig;
    logic          w_lt;
    logic [RW-1:0] w_sum;
    logic [RW-1:0] w_diff;
    logic [RW-1:0] w_prod;
    logic          w_done;
    logic [W-1:0]  w_quo;
    logic [W-1:0]  w_rem;

    assign w_evt   = mouseclick & ~r_click_d;
    assign w_key   = w_evt ? hit_test(mousex, mousey) : K_NONE;
    assign w_clr   = (w_key == K_CLR);
    assign w_digit = W'(w_key);
    assign w_a_dig = r_a * W'(10) + w_digit;
    assign w_b_dig = r_b * W'(10) + w_digit;
    assign w_lt    = (r_a < r_b);
    assign w_sum   = RW'(r_a) + RW'(r_b);
    assign w_diff  = w_lt ? RW'(r_b - r_a) : RW'(r_a - r_b);
    assign w_prod  = RW'(r_a) * RW'(r_b);

    calcu_divider #(.W(W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_start    (w_start),
        .i_dividend (r_a),
        .i_divisor  (r_b),
        .o_done     (w_done),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_cnta_nx  = r_cnta;
        w_cntb_nx  = r_cntb;
        w_val_nx   = r_val;
        w_neg_nx   = r_neg;
        w_sym_nx   = r_sym;
        w_err_nx   = r_err;
        w_start    = 1'b0;
        case (r_state)
            S_A: begin
                if (is_digit(w_key) && r_cnta < CW'(DIGITS)) begin
                    w_a_nx    = w_a_dig;
                    w_cnta_nx = r_cnta + CW'(1);
                    w_val_nx  = RW'(w_a_dig);
                end else if (is_op(w_key) && r_cnta != '0) begin
                    w_sym_nx   = key_sym(w_key);
                    w_state_nx = S_B;
                end
            end
            S_B: begin
                if (is_digit(w_key) && r_cntb < CW'(DIGITS)) begin
                    w_b_nx    = w_b_dig;
                    w_cntb_nx = r_cntb + CW'(1);
                    w_val_nx  = RW'(w_b_dig);
                end else if (is_op(w_key) && r_cntb == '0) begin
                    w_sym_nx = key_sym(w_key);
                end else if (w_key == K_EQ && r_cntb != '0) begin
                    case (r_sym)
                        SYM_ADD: begin
                            w_val_nx   = w_sum;
                            w_state_nx = S_RES;
                        end
                        SYM_SUB: begin
                            w_val_nx   = w_diff;
                            w_neg_nx   = w_lt;
                            w_state_nx = S_RES;
                        end
                        SYM_MUL: begin
                            w_val_nx   = w_prod;
                            w_state_nx = S_RES;
                        end
                        SYM_DIV, SYM_MOD: begin
                            if (r_b == '0) begin
                                w_err_nx   = 1'b1;
                                w_state_nx = S_ERR;
                            end else begin
                                w_start    = 1'b1;
                                w_state_nx = S_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_DIV: begin
                if (w_done) begin
                    w_val_nx   = RW'((r_sym == SYM_DIV) ? w_quo : w_rem);
                    w_state_nx = S_RES;
                end
            end
            S_RES: begin
                if (is_digit(w_key)) begin
                    w_a_nx     = w_digit;
                    w_cnta_nx  = CW'(1);
                    w_b_nx     = '0;
                    w_cntb_nx  = '0;
                    w_sym_nx   = SYM_NONE;
                    w_neg_nx   = 1'b0;
                    w_val_nx   = RW'(w_digit);
                    w_state_nx = S_A;
                end else if (is_op(w_key) && !r_neg &&
                             r_val < RW'(LIMIT)) begin
                    // chain: previous result becomes a full-length A
                    w_a_nx     = r_val[W-1:0];
                    w_cnta_nx  = CW'(DIGITS);
                    w_b_nx     = '0;
                    w_cntb_nx  = '0;
                    w_sym_nx   = key_sym(w_key);
                    w_state_nx = S_B;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_click_d <= 1'b1;
        else     r_click_d <= mouseclick;
    end

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_cnta  <= '0;
            r_cntb  <= '0;
            r_val   <= '0;
            r_neg   <= 1'b0;
            r_sym   <= SYM_NONE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_cnta  <= w_cnta_nx;
            r_cntb  <= w_cntb_nx;
            r_val   <= w_val_nx;
            r_neg   <= w_neg_nx;
            r_sym   <= w_sym_nx;
            r_err   <= w_err_nx;
        end
    end

    assign disp_value = r_val;
    assign disp_neg   = r_neg;
    assign disp_sym   = r_sym;
    assign busy       = (r_state == S_DIV);
    assign err        = r_err;

endmodule

// File: tb/tb_calcu_core.sv
// Directed bench for calcu_core: keystroke-string vector table
// plus timing, geometry and reset corner sequences.
module tb_calcu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  mousex;
    logic [9:0]  mousey;
    logic        mouseclick;
    logic [19:0] disp_value;
    logic        disp_neg;
    logic [6:0]  disp_sym;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    string layout = "123=456%789/0+-*";

    typedef struct {
        string seq;
        int    val;
        bit    neg;
        int    sym;
        bit    err;
    } vec_t;

    localparam int NV = 20;
    vec_t v[NV];

    always #5 clk = ~clk;

    calcu_core dut (
        .clk        (clk),
        .rst        (rst),
        .mousex     (mousex),
        .mousey     (mousey),
        .mouseclick (mouseclick),
        .disp_value (disp_value),
        .disp_neg   (disp_neg),
        .disp_sym   (disp_sym),
        .busy       (busy),
        .err        (err)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    task automatic pos(input byte ch);
        if (ch == "c") begin
            mousex = 10'd592;
            mousey = 10'd182;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (layout[i] == ch) begin
                    mousex = 10'(90 + 128 * (i % 4) + 32);
                    mousey = 10'(150 + 89 * (i / 4) + 32);
                end
            end
        end
    endtask

    task automatic click(input byte ch);
        @(posedge clk); #1;
        pos(ch);
        mouseclick = 1'b1;
        @(posedge clk); #1;
        mouseclick = 1'b0;
    endtask

    task automatic click_xy(input int x, input int y);
        @(posedge clk); #1;
        mousex = 10'(x);
        mousey = 10'(y);
        mouseclick = 1'b1;
        @(posedge clk); #1;
        mouseclick = 1'b0;
    endtask

    task automatic press(input string s);
        for (int i = 0; i < s.len(); i++) click(s[i]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic check_reset(input string name);
        check({name, " val"}, disp_value, 0);
        check({name, " neg"}, disp_neg, 0);
        check({name, " sym"}, disp_sym, 103);
        check({name, " busy"}, busy, 0);
        check({name, " err"}, err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        v[0]  = '{"12+34=",   46,     1'b0, 99,  1'b0};
        v[1]  = '{"7-9=",     2,      1'b1, 100, 1'b0};
        v[2]  = '{"3+*4=",    12,     1'b0, 101, 1'b0};
        v[3]  = '{"1234",     123,    1'b0, 103, 1'b0};
        v[4]  = '{"999/7=",   142,    1'b0, 98,  1'b0};
        v[5]  = '{"999%7=",   5,      1'b0, 97,  1'b0};
        v[6]  = '{"5/0=",     0,      1'b0, 98,  1'b1};
        v[7]  = '{"5/0=12",   0,      1'b0, 98,  1'b1};
        v[8]  = '{"5/0=c",    0,      1'b0, 103, 1'b0};
        v[9]  = '{"999*999=", 998001, 1'b0, 101, 1'b0};
        v[10] = '{"2+3=*4=",  20,     1'b0, 101, 1'b0};
        v[11] = '{"2+3=7",    7,      1'b0, 103, 1'b0};
        v[12] = '{"1-2=+",    1,      1'b1, 100, 1'b0};
        v[13] = '{"=+5",      5,      1'b0, 103, 1'b0};
        v[14] = '{"8-8=",     0,      1'b0, 100, 1'b0};
        v[15] = '{"12+=",     12,     1'b0, 99,  1'b0};
        v[16] = '{"999+1=+",  1000,   1'b0, 99,  1'b0};
        v[17] = '{"1+2345=",  235,    1'b0, 99,  1'b0};
        v[18] = '{"999/1=",   999,    1'b0, 98,  1'b0};
        v[19] = '{"7%9=",     7,      1'b0, 97,  1'b0};

        rst        = 1'b1;
        mouseclick = 1'b0;
        mousex     = '0;
        mousey     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset("reset");

        for (int i = 0; i < NV; i++) begin
            press({"c", v[i].seq});
            wait_idle($sformatf("v%0d idle", i));
            check($sformatf("v%0d val", i), disp_value, v[i].val);
            check($sformatf("v%0d neg", i), disp_neg, v[i].neg);
            check($sformatf("v%0d sym", i), disp_sym, v[i].sym);
            check($sformatf("v%0d err", i), err, v[i].err);
        end

        // busy must last exactly W=10 cycles after '='
        press("c999/7");
        @(posedge clk); #1;
        pos("=");
        mouseclick = 1'b1;
        @(posedge clk); #1;
        mouseclick = 1'b0;
        check("div busy start", busy, 1);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("div busy cycles", n, 10);
        check("div result", disp_value, 142);

        // held button: exactly one event
        press("c");
        @(posedge clk); #1;
        pos("8");
        mouseclick = 1'b1;
        repeat (100) @(posedge clk);
        #1 mouseclick = 1'b0;
        @(posedge clk); #1;
        check("hold val", disp_value, 8);

        // key edges
        press("c");
        click_xy(154, 150);
        check("edge 154,150", disp_value, 1);
        click_xy(90, 214);
        check("edge 90,214", disp_value, 11);
        click_xy(155, 150);
        check("gap 155,150", disp_value, 11);
        click_xy(154, 215);
        check("gap 154,215", disp_value, 11);
        click_xy(624, 214);
        check("clr corner", disp_value, 0);

        // clear aborts a running division
        press("c999/7=");
        repeat (3) @(posedge clk);
        #1 check("clr div busy", busy, 1);
        click("c");
        check_reset("clr div");
        repeat (15) @(posedge clk);
        #1 check("clr div later", disp_value, 0);
        check("clr div later busy", busy, 0);

        // rst aborts a running division
        press("c999%7=");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset("rst div");
        repeat (15) @(posedge clk);
        #1 check("rst div later", disp_value, 0);

        // button held through reset generates nothing
        @(posedge clk); #1;
        pos("5");
        mouseclick = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("held rst val", disp_value, 0);
        mouseclick = 1'b0;
        @(posedge clk); #1;
        check("held rst release", disp_value, 0);
        click("5");
        check("after held rst", disp_value, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
